// File: rtl/full_subtractor.sv
// full_subtractor: registered ripple-borrow subtractor with zero and signed-overflow flags
module full_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;
    assign br[0] = bin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    // Capture a result on every valid beat; hold the last result otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d    <= diff;
                bout <= br[WIDTH];
                ovf  <= br[WIDTH] ^ br[WIDTH-1];
            end
        end
    end
    assign zero = ~|d;
endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: scoreboard bench for full_subtractor at WIDTH 1, 4 and 8
module tb_full_subtractor;
    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       v1 = 0, a1 = 0, b1 = 0, bin1 = 0, ov1, d1, bo1, z1, of1;
    logic       v4 = 0, bin4 = 0, ov4, bo4, z4, of4;
    logic [3:0] a4 = 0, b4 = 0, d4;
    logic       v8 = 0, bin8 = 0, ov8, bo8, z8, of8;
    logic [7:0] a8 = 0, b8 = 0, d8;

    exp_t q1[$], q4[$], q8[$];
    int checks = 0;
    int errors = 0;

    full_subtractor #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .d(d1), .bout(bo1), .zero(z1), .ovf(of1));
    full_subtractor #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .bin(bin4),
        .out_valid(ov4), .d(d4), .bout(bo4), .zero(z4), .ovf(of4));
    full_subtractor #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .d(d8), .bout(bo8), .zero(z8), .ovf(of8));

    // Integer reference: unsigned subtract for d/bout, signed range test for ovf
    function automatic exp_t model(int w, int a, int b, int bin);
        exp_t e;
        int full, half, sa, sb, r, m;
        half = 1 << (w - 1);
        full = a - b - bin;
        m = full & ((1 << w) - 1);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        r = sa - sb - bin;
        e.d = 8'(m);
        e.bout = full < 0;
        e.ovf = (r < -half) || (r >= half);
        e.zero = m == 0;
        return e;
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({ov1, d1, bo1, of1, z1} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_w1 got v/d/bout/ovf/zero=%b required=00001", {ov1, d1, bo1, of1, z1});
        end
        checks++;
        if ({ov4, d4, bo4, of4, z4} !== {1'b0, 4'h0, 3'b001}) begin
            errors++;
            $display("FAIL reset_w4 got v=%b d=%h bout=%b ovf=%b zero=%b required 0/0/0/0/1", ov4, d4, bo4, of4, z4);
        end
        checks++;
        if ({ov8, d8, bo8, of8, z8} !== {1'b0, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL reset_w8 got v=%b d=%h bout=%b ovf=%b zero=%b required 0/0/0/0/1", ov8, d8, bo8, of8, z8);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_truth_w1();
        logic [7:0] d_tab = 8'b1001_0110;
        logic [7:0] b_tab = 8'b1000_1110;
        logic [2:0] idx;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            @(negedge clk);
            v1 = 1'b1; a1 = idx[2]; b1 = idx[1]; bin1 = idx[0];
            q1.push_back('{d: {7'b0, d_tab[idx]}, bout: b_tab[idx], ovf: b_tab[idx] ^ idx[0], zero: ~d_tab[idx]});
            @(posedge clk); #1;
            checks++;
            if (ov1 !== 1'b1 || q1.size() == 0) begin
                errors++;
                $display("FAIL w1_valid abc=%b got out_valid=%b queued=%0d required 1", idx, ov1, q1.size());
            end else begin
                e = q1.pop_front();
                checks++;
                if ({d1, bo1, of1, z1} !== {e.d[0], e.bout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL w1_truth abc=%b got d/bout/ovf/zero=%b required=%b", idx,
                             {d1, bo1, of1, z1}, {e.d[0], e.bout, e.ovf, e.zero});
                end
            end
        end
        @(negedge clk) v1 = 1'b0;
    endtask

    task automatic test_boundaries_w4();
        logic [3:0] ta[4] = '{4'h0, 4'h0, 4'h8, 4'h7};
        logic [3:0] tb[4] = '{4'h1, 4'hF, 4'h1, 4'hF};
        logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] td[4] = '{4'hF, 4'h0, 4'h7, 4'h8};
        logic       tbo[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       tov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v4 = 1'b1; a4 = ta[k]; b4 = tb[k]; bin4 = tc[k];
            q4.push_back('{d: {4'b0, td[k]}, bout: tbo[k], ovf: tov[k], zero: td[k] == 4'h0});
            @(posedge clk); #1;
            checks++;
            if (ov4 !== 1'b1 || q4.size() == 0) begin
                errors++;
                $display("FAIL w4_edge_valid case=%0d got out_valid=%b required 1", k, ov4);
            end else begin
                e = q4.pop_front();
                checks++;
                if ({d4, bo4, of4, z4} !== {e.d[3:0], e.bout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL w4_edge case=%0d got d=%h bout=%b ovf=%b zero=%b required d=%h bout=%b ovf=%b zero=%b",
                             k, d4, bo4, of4, z4, e.d[3:0], e.bout, e.ovf, e.zero);
                end
            end
        end
        @(negedge clk) v4 = 1'b0;
    endtask

    task automatic test_valid_gap();
        logic       pv[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] pa[4] = '{4'h9, 4'h5, 4'hC, 4'h6};
        logic [3:0] pb[4] = '{4'h2, 4'h3, 4'h1, 4'h6};
        logic       pc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] last_d = 4'h0;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v4 = pv[k]; a4 = pa[k]; b4 = pb[k]; bin4 = pc[k];
            if (pv[k]) q4.push_back(model(4, int'(pa[k]), int'(pb[k]), int'(pc[k])));
            @(posedge clk); #1;
            checks++;
            if (ov4 !== pv[k]) begin
                errors++;
                $display("FAIL gap_valid beat=%0d got out_valid=%b required %b", k, ov4, pv[k]);
            end
            if (pv[k] && q4.size() != 0) begin
                e = q4.pop_front();
                last_d = e.d[3:0];
                checks++;
                if ({d4, bo4, of4, z4} !== {e.d[3:0], e.bout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL gap_result beat=%0d got d=%h bout=%b ovf=%b zero=%b required d=%h bout=%b ovf=%b zero=%b",
                             k, d4, bo4, of4, z4, e.d[3:0], e.bout, e.ovf, e.zero);
                end
            end else if (!pv[k]) begin
                checks++;
                if (d4 !== last_d) begin
                    errors++;
                    $display("FAIL gap_hold beat=%0d got d=%h required held %h", k, d4, last_d);
                end
            end
        end
        @(negedge clk) v4 = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        v4 = 1'b1; a4 = 4'h5; b4 = 4'h0; bin4 = 1'b0;
        @(posedge clk); #1;
        v4 = 1'b0;
        checks++;
        if (ov4 !== 1'b1 || d4 !== 4'h5) begin
            errors++;
            $display("FAIL areset_pre got out_valid=%b d=%h required 1/5", ov4, d4);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov4, d4, bo4, of4, z4} !== {1'b0, 4'h0, 3'b001}) begin
            errors++;
            $display("FAIL areset_now got v=%b d=%h bout=%b ovf=%b zero=%b required 0/0/0/0/1", ov4, d4, bo4, of4, z4);
        end
        @(negedge clk);
        v4 = 1'b1; a4 = 4'h9; b4 = 4'h3;
        @(posedge clk); #1;
        checks++;
        if (ov4 !== 1'b0 || d4 !== 4'h0) begin
            errors++;
            $display("FAIL areset_hold got out_valid=%b d=%h required 0/0", ov4, d4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v4 = 1'b1; a4 = 4'h3; b4 = 4'h1; bin4 = 1'b0;
        q4.push_back(model(4, 3, 1, 0));
        @(posedge clk); #1;
        checks++;
        if (ov4 !== 1'b1 || q4.size() == 0) begin
            errors++;
            $display("FAIL areset_first_valid got out_valid=%b required 1", ov4);
        end else begin
            e = q4.pop_front();
            checks++;
            if ({d4, bo4, of4, z4} !== {e.d[3:0], e.bout, e.ovf, e.zero}) begin
                errors++;
                $display("FAIL areset_first got d=%h bout=%b ovf=%b zero=%b required d=%h bout=%b ovf=%b zero=%b",
                         d4, bo4, of4, z4, e.d[3:0], e.bout, e.ovf, e.zero);
            end
        end
        @(negedge clk) v4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] last_d = d8;
        logic       vv;
        exp_t e;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            vv = $urandom_range(0, 9) != 0;
            v8 = vv; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            if (vv) q8.push_back(model(8, int'(a8), int'(b8), int'(bin8)));
            @(posedge clk); #1;
            checks++;
            if (ov8 !== vv) begin
                errors++;
                $display("FAIL rand_valid iter=%0d got out_valid=%b required %b", k, ov8, vv);
            end else if (vv && q8.size() != 0) begin
                e = q8.pop_front();
                last_d = e.d;
                checks++;
                if ({d8, bo8, of8, z8} !== {e.d, e.bout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL rand_result iter=%0d got d=%h bout=%b ovf=%b zero=%b required d=%h bout=%b ovf=%b zero=%b",
                             k, d8, bo8, of8, z8, e.d, e.bout, e.ovf, e.zero);
                end
            end else if (!vv) begin
                checks++;
                if (d8 !== last_d) begin
                    errors++;
                    $display("FAIL rand_hold iter=%0d got d=%h required held %h", k, d8, last_d);
                end
            end
        end
        @(negedge clk) v8 = 1'b0;
        checks++;
        if (q1.size() + q4.size() + q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q1.size() + q4.size() + q8.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_truth_w1();
        test_boundaries_w4();
        test_valid_gap();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered, parameterizable ripple-borrow subtractor built from 1-bit full-subtract cells.
- Computes D = A − B − Bin and produces the final borrow, plus zero and signed-overflow flags.
- Sits in datapaths that need a clean, synchronous subtract stage with a valid qualifier.
- At WIDTH=1 it reproduces the classic 1-bit full-subtractor truth table, one cycle late.

Parameters:
WIDTH, 4, operand and difference width in bits (≥1).

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
in_valid input  1      operands valid this cycle; a, b and bin are sampled when high
a       input   WIDTH  minuend (unsigned, or two's complement for ovf)
b       input   WIDTH  subtrahend
bin     input   1      borrow-in
out_valid output 1     d, bout, zero and ovf hold a new result
d       output  WIDTH  difference, (a − b − bin) mod 2^WIDTH
bout    output  1      borrow-out from the MSB cell
zero    output  1      high when d == 0
ovf     output  1      signed overflow of a − b − bin

Behaviour:
- Cell i computes:
  - d[i] = a[i] ^ b[i] ^ br[i]
  - br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])
  - br[0] = bin and bout = br[WIDTH].
- Equivalent form: {bout, d} = {1'b0, a} − {1'b0, b} − bin, computed in WIDTH+1 bits. bout = 1 exactly when a < b + bin (unsigned).
- ovf = br[WIDTH] ^ br[WIDTH−1], which equals the signed overflow of a − b − bin. For WIDTH=1, ovf = bout ^ bin.
- zero = ~|d of the registered result.
- Latency: one clock.
  - When in_valid is high at edge N, the results appear after edge N and out_valid = 1 for that cycle.
- When in_valid is low at an edge:
  - out_valid goes to 0.
  - d, bout, zero and ovf hold their last values.
- Back-to-back in_valid gives one result per cycle, with no stall and no back-pressure.
- Reset:
  - rst_n low asynchronously forces out_valid = 0, d = 0, bout = 0, ovf = 0 and zero = 1, independent of clk.
  - Outputs are consistent with d = 0.
  - The first result can appear on the first rising edge after rst_n deasserts with in_valid high.
  - If reset asserts mid-operation, the in-flight result is discarded.
- Wrap-around: 0 − 1 with bin = 0 gives d = all ones and bout = 1. 0 − 0 with bin = 1 gives the same.
- Maximum borrow case: a = 0, b = all ones, bin = 1 gives d = 0, bout = 1, zero = 1.
- No internal state beyond the output registers. All inputs are fully combinational into the registers.

Test Plan:
- WIDTH=1, sweep all 8 (a, b, bin) combinations with in_valid = 1.
  - Required d/bout for (a, b, bin):
    - 000 → 0/0
    - 010 → 1/1
    - 100 → 1/0
    - 110 → 0/0
    - 001 → 1/1
    - 011 → 0/1
    - 101 → 0/0
    - 111 → 1/1
  - Each result appears one cycle after sampling.
- WIDTH=4, a = 4'h0, b = 4'h1, bin = 0 → d = 4'hF, bout = 1, zero = 0, ovf = 0. Then a = 4'h0, b = 4'hF, bin = 1 → d = 4'h0, bout = 1, zero = 1.
- WIDTH=4, signed overflow:
  - a = 4'h8, b = 4'h1, bin = 0 → d = 4'h7, ovf = 1, bout = 0.
  - a = 4'h7, b = 4'hF, bin = 0 → d = 4'h8, ovf = 1, bout = 1.
- Valid handling: drive in_valid 1, 1, 0, 1 with distinct operands.
  - out_valid must be 1, 1, 0, 1 delayed by one cycle.
  - d must hold its value during the gap.
- Async reset: assert rst_n = 0 between clock edges while out_valid = 1 and d = 4'h5.
  - Outputs must go immediately to out_valid = 0, d = 0, bout = 0, ovf = 0, zero = 1.
  - After release, the first in_valid produces a correct result.
- Randomized: 1000 random (a, b, bin) triples at WIDTH=8 compared against the WIDTH+1-bit reference subtraction for d, bout, zero and ovf.
